// File: rtl/pht_update_scheduler_pkg.sv
// Shared fetch-unit PHT types: index/entry paths, queue entry,
// bank-conflict check and saturating counter update.
package pht_update_scheduler_pkg;

  localparam int PHT_ENTRY_NUM = 256;
  localparam int PHT_ENTRY_NUM_BIT_WIDTH = $clog2(PHT_ENTRY_NUM);
  localparam int PHT_BANK_NUM = 2;
  localparam int PHT_BANK_NUM_BIT_WIDTH = $clog2(PHT_BANK_NUM);
  localparam int PHT_QUEUE_SIZE = 32;
  localparam int PHT_QUEUE_SIZE_BIT_WIDTH = $clog2(PHT_QUEUE_SIZE);
  localparam logic [1:0] PHT_ENTRY_MAX = 2'd3;

  typedef logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0] PHT_IndexPath;
  typedef logic [1:0] PHT_EntryPath;
  typedef logic [PHT_QUEUE_SIZE_BIT_WIDTH-1:0] PhtQueuePointerPath;

  typedef struct packed {
    PHT_IndexPath index;
    PHT_EntryPath value;
  } PhtQueueEntry;

  typedef enum logic {
    INIT,
    RUN
  } PhtUpdateState;

  // Banks are interleaved on the low index bits.
  function automatic logic IsBankConflict(
    input PHT_IndexPath a,
    input PHT_IndexPath b
  );
    return a[PHT_BANK_NUM_BIT_WIDTH-1:0] == b[PHT_BANK_NUM_BIT_WIDTH-1:0];
  endfunction

  function automatic PHT_EntryPath PhtCounterUpdate(
    input PHT_EntryPath prev,
    input logic taken
  );
    if (taken)
      return (prev == PHT_ENTRY_MAX) ? PHT_ENTRY_MAX : prev + 2'd1;
    else
      return (prev == 2'd0) ? 2'd0 : prev - 2'd1;
  endfunction

endpackage

// File: rtl/pht_update_queue.sv
// Circular FIFO of pending PHT writes with head/tail/count
// and full/empty flags.
module pht_update_queue
  import pht_update_scheduler_pkg::*;
#(
  parameter int DEPTH = PHT_QUEUE_SIZE
) (
  input  logic clk,
  input  logic rst,
  input  logic enq,
  input  PhtQueueEntry enqData,
  input  logic deq,
  output PhtQueueEntry headData,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  PhtQueueEntry mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= enqData;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      if (enq && !deq)
        count <= count + 1'b1;
      else if (!enq && deq)
        count <= count - 1'b1;
    end
  end

  assign headData = mem[head];
  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/pht_update_scheduler.sv
// Sequences PHT writes: reset-time init sweep, then queued
// commit-side counter updates deferred around fetch bank conflicts.
module pht_update_scheduler
  import pht_update_scheduler_pkg::*;
#(
  parameter int QUEUE_DEPTH = PHT_QUEUE_SIZE,
  parameter int STALL_THRESHOLD = 28,
  parameter PHT_EntryPath PHT_INIT_VALUE = 2'b01,
  parameter int PHT_ENTRIES = PHT_ENTRY_NUM
) (
  input  logic clk,
  input  logic rst,
  input  logic brValid,
  input  logic brIsCondBr,
  input  logic brExecTaken,
  input  PHT_IndexPath brPhtIndex,
  input  PHT_EntryPath brPhtPrevValue,
  input  logic fetchReadValid,
  input  PHT_IndexPath fetchReadIndex,
  output logic phtWE,
  output PHT_IndexPath phtWA,
  output PHT_EntryPath phtWV,
  output logic initBusy,
  output logic stallFetch,
  output logic [15:0] dropCount
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam PHT_IndexPath LAST_INDEX = PHT_IndexPath'(PHT_ENTRIES - 1);

  PhtUpdateState state;
  PHT_IndexPath sweepPtr;
  PhtQueueEntry enqEntry;
  PhtQueueEntry headEntry;
  logic [CW-1:0] count;
  logic enqReq, enq, deq, full, empty, conflict;

  assign enqReq   = brValid && brIsCondBr;
  assign enqEntry = '{index: brPhtIndex,
                      value: PhtCounterUpdate(brPhtPrevValue, brExecTaken)};
  assign conflict = fetchReadValid
                 && IsBankConflict(headEntry.index, fetchReadIndex);
  assign deq = !rst && (state == RUN) && !empty && !conflict;
  // A full queue still accepts when the head leaves this cycle.
  assign enq = !rst && enqReq && (!full || deq);

  pht_update_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .enq     (enq),
    .enqData (enqEntry),
    .deq     (deq),
    .headData(headEntry),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      sweepPtr  <= '0;
      dropCount <= '0;
    end else begin
      if (state == INIT) begin
        sweepPtr <= sweepPtr + 1'b1;
        if (sweepPtr == LAST_INDEX) state <= RUN;
      end
      if (enqReq && full && !deq && dropCount != 16'hFFFF)
        dropCount <= dropCount + 16'd1;
    end
  end

  always_comb begin
    phtWE = deq;
    phtWA = headEntry.index;
    phtWV = headEntry.value;
    if (state == INIT) begin
      phtWE = !rst;
      phtWA = sweepPtr;
      phtWV = PHT_INIT_VALUE;
    end
  end

  assign initBusy   = rst || (state == INIT);
  assign stallFetch = initBusy || (count >= CW'(STALL_THRESHOLD));

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Directed bench for pht_update_scheduler: table vectors for single
// updates plus sequences for init sweep, conflicts, full queue and reset.
module tb_pht_update_scheduler;
  import pht_update_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic brValid, brIsCondBr, brExecTaken;
  logic [7:0] brPhtIndex;
  logic [1:0] brPhtPrevValue;
  logic fetchReadValid;
  logic [7:0] fetchReadIndex;
  logic phtWE;
  logic [7:0] phtWA;
  logic [1:0] phtWV;
  logic initBusy, stallFetch;
  logic [15:0] dropCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic isCond;
    logic taken;
    logic [1:0] prev;
    logic [7:0] idx;
    logic fVal;
    logic [7:0] fIdx;
    logic expWE;
    logic [1:0] expWV;
  } vec_t;

  typedef struct {
    logic [7:0] idx;
    logic [1:0] val;
  } ent_t;

  vec_t vecs[8];
  ent_t model[$];

  pht_update_scheduler #(
    .QUEUE_DEPTH(32),
    .STALL_THRESHOLD(28),
    .PHT_INIT_VALUE(2'b01),
    .PHT_ENTRIES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .brValid(brValid),
    .brIsCondBr(brIsCondBr),
    .brExecTaken(brExecTaken),
    .brPhtIndex(brPhtIndex),
    .brPhtPrevValue(brPhtPrevValue),
    .fetchReadValid(fetchReadValid),
    .fetchReadIndex(fetchReadIndex),
    .phtWE(phtWE),
    .phtWA(phtWA),
    .phtWV(phtWV),
    .initBusy(initBusy),
    .stallFetch(stallFetch),
    .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] sat(input logic [1:0] prev,
                                     input logic taken);
    int v;
    v = taken ? int'(prev) + 1 : int'(prev) - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  task automatic br(input logic v, input logic c, input logic t,
                    input logic [7:0] idx, input logic [1:0] prev);
    brValid = v;
    brIsCondBr = c;
    brExecTaken = t;
    brPhtIndex = idx;
    brPhtPrevValue = prev;
  endtask

  // Entered right after rst drops; checks one write per cycle.
  task automatic sweep();
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("init_we", 32'(phtWE), 32'd1);
      chk("init_wa", 32'(phtWA), 32'(i));
      chk("init_wv", 32'(phtWV), 32'd1);
      chk("init_busy", 32'(initBusy), 32'd1);
      @(negedge clk);
    end
    #1;
    chk("init_done_busy", 32'(initBusy), 32'd0);
    chk("init_done_we", 32'(phtWE), 32'd0);
    chk("init_done_stall", 32'(stallFetch), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 2'd3, 8'h12, 1'b0, 8'h00, 1'b1, 2'd3};
    vecs[1] = '{1'b1, 1'b0, 2'd0, 8'h12, 1'b0, 8'h00, 1'b1, 2'd0};
    vecs[2] = '{1'b1, 1'b1, 2'd1, 8'h34, 1'b1, 8'h09, 1'b1, 2'd2};
    vecs[3] = '{1'b1, 1'b0, 2'd2, 8'h35, 1'b0, 8'h00, 1'b1, 2'd1};
    vecs[4] = '{1'b1, 1'b1, 2'd2, 8'h56, 1'b0, 8'h00, 1'b1, 2'd3};
    vecs[5] = '{1'b1, 1'b0, 2'd3, 8'h57, 1'b0, 8'h00, 1'b1, 2'd2};
    vecs[6] = '{1'b0, 1'b1, 2'd1, 8'h77, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[7] = '{1'b1, 1'b1, 2'd0, 8'h78, 1'b0, 8'h00, 1'b1, 2'd1};

    rst = 1'b1;
    br(1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
    fetchReadValid = 1'b0;
    fetchReadIndex = 8'h00;

    @(negedge clk);
    #1;
    chk("rst_we", 32'(phtWE), 32'd0);
    chk("rst_busy", 32'(initBusy), 32'd1);
    chk("rst_stall", 32'(stallFetch), 32'd1);
    chk("rst_drop", 32'(dropCount), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sweep();

    // Single updates: no bypass, written the following cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      br(1'b1, vecs[i].isCond, vecs[i].taken, vecs[i].idx, vecs[i].prev);
      #1;
      chk("vec_nobypass", 32'(phtWE), 32'd0);
      @(negedge clk);
      br(1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
      fetchReadValid = vecs[i].fVal;
      fetchReadIndex = vecs[i].fIdx;
      #1;
      chk("vec_we", 32'(phtWE), 32'(vecs[i].expWE));
      if (vecs[i].expWE) begin
        chk("vec_wa", 32'(phtWA), 32'(vecs[i].idx));
        chk("vec_wv", 32'(phtWV), 32'(vecs[i].expWV));
      end
      fetchReadValid = 1'b0;
    end

    // Bank conflict holds the head entry.
    @(negedge clk);
    br(1'b1, 1'b1, 1'b1, 8'h04, 2'd1);
    fetchReadValid = 1'b1;
    fetchReadIndex = 8'h08;
    #1;
    chk("cf_enq_we", 32'(phtWE), 32'd0);
    @(negedge clk);
    br(1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
    #1;
    chk("cf_hold_we", 32'(phtWE), 32'd0);
    @(negedge clk);
    fetchReadValid = 1'b0;
    #1;
    chk("cf_rel_we", 32'(phtWE), 32'd1);
    chk("cf_rel_wa", 32'(phtWA), 32'h04);
    chk("cf_rel_wv", 32'(phtWV), 32'd2);
    @(negedge clk);
    #1;
    chk("cf_empty_we", 32'(phtWE), 32'd0);

    // Fill behind a conflicting fetch read; 33rd update is dropped.
    fetchReadValid = 1'b1;
    fetchReadIndex = 8'h00;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      br(1'b1, 1'b1, 1'(i), 8'(2 * i), 2'(i % 4));
      #1;
      chk("fill_we", 32'(phtWE), 32'd0);
      chk("fill_stall", 32'(stallFetch), 32'(i >= 28));
      if (i < 32) model.push_back('{8'(2 * i), sat(2'(i % 4), 1'(i))});
    end
    @(negedge clk);
    br(1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
    #1;
    chk("full_drop", 32'(dropCount), 32'd1);
    chk("full_stall", 32'(stallFetch), 32'd1);

    // Full queue: enqueue alongside a dequeue is accepted.
    @(negedge clk);
    fetchReadValid = 1'b0;
    br(1'b1, 1'b1, 1'b1, 8'hFE, 2'd1);
    #1;
    chk("fullx_we", 32'(phtWE), 32'd1);
    chk("fullx_wa", 32'(phtWA), 32'(model[0].idx));
    chk("fullx_wv", 32'(phtWV), 32'(model[0].val));
    void'(model.pop_front());
    model.push_back('{8'hFE, 2'd2});
    while (model.size() > 0) begin
      @(negedge clk);
      br(1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
      #1;
      chk("drain_stall", 32'(stallFetch), 32'(model.size() >= 28));
      chk("drain_we", 32'(phtWE), 32'd1);
      chk("drain_wa", 32'(phtWA), 32'(model[0].idx));
      chk("drain_wv", 32'(phtWV), 32'(model[0].val));
      chk("drain_drop", 32'(dropCount), 32'd1);
      void'(model.pop_front());
    end
    @(negedge clk);
    #1;
    chk("drain_done_we", 32'(phtWE), 32'd0);

    // Reset with queued entries discards them and re-sweeps.
    fetchReadValid = 1'b1;
    fetchReadIndex = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      br(1'b1, 1'b1, 1'b0, 8'(2 * i + 8'h20), 2'd2);
    end
    @(negedge clk);
    br(1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
    rst = 1'b1;
    #1;
    chk("mrst_we", 32'(phtWE), 32'd0);
    chk("mrst_busy", 32'(initBusy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    fetchReadValid = 1'b0;
    sweep();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("mrst_noq_we", 32'(phtWE), 32'd0);
    end
    chk("mrst_drop", 32'(dropCount), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pht_update_scheduler.md
Name: pht_update_scheduler

Overview:
- Sequences every write into the gshare PHT: a reset-time sweep that initialises all counters, then a FIFO of committed conditional-branch updates.
- Computes the new saturating 2-bit counter from the prediction-time value and the executed direction.
- Retires queued updates one per cycle into the PHT write port, deferring on bank conflict with the fetch-stage PHT read.
- Sits between the commit-side branch result path and the PHT storage; raises a fetch stall when the queue nears full.

Parameters:
- QUEUE_DEPTH, 32 (PHT_QUEUE_SIZE): update FIFO entries; power of two.
- STALL_THRESHOLD, 28: occupancy at or above which stallFetch is asserted.
- PHT_INIT_VALUE, 2'b01: counter value written during the init sweep (weakly not-taken).
- PHT_ENTRIES, PHT_ENTRY_NUM: number of entries swept during init.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- brValid  in  1  branch result valid this cycle
- brIsCondBr  in  1  result is a conditional branch
- brExecTaken  in  1  executed direction
- brPhtIndex  in  PHT_ENTRY_NUM_BIT_WIDTH  PHT index used at prediction
- brPhtPrevValue  in  2  counter value read at prediction
- fetchReadValid  in  1  fetch stage reads PHT this cycle
- fetchReadIndex  in  PHT_ENTRY_NUM_BIT_WIDTH  fetch read index
- phtWE  out  1  PHT write enable
- phtWA  out  PHT_ENTRY_NUM_BIT_WIDTH  PHT write index
- phtWV  out  2  PHT write value
- initBusy  out  1  init sweep in progress
- stallFetch  out  1  high while initBusy, or while count >= STALL_THRESHOLD
- dropCount  out  16  saturating count of updates lost to a full queue

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- FSM states: INIT, RUN.
- Reset: state=INIT, sweep pointer=0, head=tail=count=0, dropCount=0. Outputs phtWE=0, initBusy=1, stallFetch=1.
- Reset asserted mid-operation discards all queued entries and restarts the sweep at index 0.
- INIT, per cycle: phtWE=1, phtWA=sweep pointer, phtWV=PHT_INIT_VALUE, then increment the pointer.
  - Bank conflicts are ignored; fetch is stalled throughout.
  - On the cycle writing index PHT_ENTRIES-1, next state=RUN.
  - The sweep takes exactly PHT_ENTRIES cycles; initBusy falls the cycle after the last init write.
- Enqueue condition: brValid && brIsCondBr.
  - New value = brExecTaken ? min(prev+1,3) : max(prev-1,0), unsigned 2-bit saturating.
  - Entry stored = {index, newValue}.
  - Enqueue is accepted in both INIT and RUN.
- Dequeue, RUN only: head is written when count!=0 and NOT (fetchReadValid && IsBankConflict(head.index, fetchReadIndex)).
  - phtWE/phtWA/phtWV are combinational from the head entry and are valid in the same cycle as the dequeue.
  - A conflicting cycle holds the head entry and drives phtWE=0.
  - Minimum latency: an entry enqueued in cycle N is written in cycle N+1.
- Full queue (count==QUEUE_DEPTH):
  - Enqueue is accepted if a dequeue occurs in the same cycle.
  - Otherwise the update is dropped, dropCount increments (saturating at 16'hFFFF), and queue state is unchanged.
- Simultaneous enqueue and dequeue: count is unchanged; head and tail pointers both advance and wrap modulo QUEUE_DEPTH.
- Empty queue with enqueue: the entry is not bypassed; it is written no earlier than the next cycle.
- Duplicate indices in the queue are written in FIFO order; no merging.
- stallFetch is combinational from state and count.

Decomposition:
- Shared fetch-unit types package:
  - PhtQueueEntry, stored as {PHT_IndexPath index; PHT_EntryPath value}.
  - PhtQueuePointerPath.
  - PHT_ENTRY_MAX.
  - IsBankConflict.
  - A new saturating-update function, PhtCounterUpdate(prev, taken).
- Sub-module: pht_update_queue, a circular FIFO with head/tail/count and full/empty flags.
- The FSM, conflict check and drop counter live in the top block.

Test Plan:
- Reset with PHT_ENTRIES=16 -> phtWE=1 for 16 consecutive cycles, phtWA=0..15, phtWV=2'b01; initBusy falls in cycle 17; no further writes.
- RUN, empty queue; enqueue index 0x12, prev=3, taken=1 -> next cycle phtWE=1, phtWA=0x12, phtWV=3. Enqueue prev=0, taken=0 -> phtWV=0.
- Head index 0x04, fetchReadValid=1, fetchReadIndex=0x08 with 2 banks -> phtWE=0. Release fetch -> write 0x04 with value 2 (prev=1, taken=1) the next cycle.
- Hold fetchReadValid with a conflicting index while enqueuing 28 updates -> stallFetch rises when count reaches 28. Enqueue 5 more -> after count hits 32, 1 drop and dropCount=1.
- Full queue, enqueue on the same cycle as a non-conflicting dequeue -> no drop, count stays 32, then entries drain in order.
- Assert rst while the queue holds 5 entries -> no queued writes appear; the init sweep restarts at index 0.
